control_sequencer: RTL

Multi-cycle control sequencer that sits directly upstream of the register file in the basic microprocessor. It fetches a 32-bit instruction through a request/valid handshake and decodes it. It then drives the register-file read/write addresses, stage enable code and write enable, and steps the PC. One instruction is in flight at a time: FETCH -> DECODE -> EXECUTE -> WRITEBACK.

---
 rtl/control_pkg.sv | 38 +++
 rtl/instr_decode.sv | 66 ++++++
 rtl/control_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared constants and types for the control sequencer.
// Opcode/funct encodings, ALU op codes, stage codes and FSM states.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [3:0] EN_IDLE   = 4'b0000;
    localparam logic [3:0] EN_FETCH  = 4'b1000;
    localparam logic [3:0] EN_DECODE = 4'b0001;
    localparam logic [3:0] EN_EXEC   = 4'b0010;
    localparam logic [3:0] EN_WB     = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct decoder.
// Unknown encodings flag illegal and fall back to a NOP.
module instr_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_write,
    output logic       dst_is_rt,
    output logic       is_branch,
    output logic       is_halt,
    output logic       illegal
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        dst_is_rt   = 1'b0;
        is_branch   = 1'b0;
        is_halt     = 1'b0;
        illegal     = 1'b0;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                unique case (1'b1)
                    funct == FN_ADD: begin
                        alu_op    = ALU_ADD;
                        reg_write = 1'b1;
                    end
                    funct == FN_SUB: begin
                        alu_op    = ALU_SUB;
                        reg_write = 1'b1;
                    end
                    funct == FN_AND: begin
                        alu_op    = ALU_AND;
                        reg_write = 1'b1;
                    end
                    funct == FN_OR: begin
                        alu_op    = ALU_OR;
                        reg_write = 1'b1;
                    end
                    funct == FN_SLT: begin
                        alu_op    = ALU_SLT;
                        reg_write = 1'b1;
                    end
                    funct == FN_NOP: illegal = 1'b0;
                    default:         illegal = 1'b1;
                endcase
            end
            opcode == OP_ADDI: begin
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
                dst_is_rt   = 1'b1;
            end
            opcode == OP_BEQ: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
            end
            opcode == OP_HALT: is_halt = 1'b1;
            default:           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
// Drives register-file addresses, write enable and the PC.
module control_sequencer
    import control_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            instr_req,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      address1,
    output logic [4:0]      address2,
    output logic [4:0]      address3,
    output logic [3:0]      en,
    output logic            enw,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic [31:0]     imm,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_e          state;
    logic            wr_q;
    logic            branch_q;
    logic            halt_q;
    logic            taken_q;
    logic [3:0]      dec_alu_op;
    logic            dec_src_imm;
    logic            dec_reg_write;
    logic            dec_dst_is_rt;
    logic            dec_branch;
    logic            dec_halt;
    logic            dec_illegal;
    logic [4:0]      dst;
    logic [PC_W-1:0] br_off;

    // Decode straight off the fetch bus so fields are valid in DECODE
    instr_decode u_dec (
        .opcode      (instr[31:26]),
        .funct       (instr[5:0]),
        .alu_op      (dec_alu_op),
        .alu_src_imm (dec_src_imm),
        .reg_write   (dec_reg_write),
        .dst_is_rt   (dec_dst_is_rt),
        .is_branch   (dec_branch),
        .is_halt     (dec_halt),
        .illegal     (dec_illegal)
    );

    assign dst    = dec_dst_is_rt ? instr[20:16] : instr[15:11];
    assign br_off = PC_W'($signed({imm, 2'b00}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_req   <= 1'b0;
            address1    <= '0;
            address2    <= '0;
            address3    <= '0;
            en          <= EN_IDLE;
            enw         <= 1'b0;
            alu_op      <= ALU_ADD;
            alu_src_imm <= 1'b0;
            imm         <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            wr_q        <= 1'b0;
            branch_q    <= 1'b0;
            halt_q      <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        en        <= EN_FETCH;
                        instr_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        state       <= S_DECODE;
                        en          <= EN_DECODE;
                        instr_req   <= 1'b0;
                        address1    <= instr[25:21];
                        address2    <= instr[20:16];
                        address3    <= dst;
                        imm         <= {{16{instr[15]}}, instr[15:0]};
                        alu_op      <= dec_alu_op;
                        alu_src_imm <= dec_src_imm;
                        illegal     <= dec_illegal;
                        wr_q        <= dec_reg_write && (dst != 5'd0);
                        branch_q    <= dec_branch;
                        halt_q      <= dec_halt;
                    end
                end
                S_DECODE: begin
                    illegal <= 1'b0;
                    if (halt_q) begin
                        state  <= S_HALT;
                        en     <= EN_IDLE;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                        en    <= EN_EXEC;
                    end
                end
                S_EXECUTE: begin
                    state   <= S_WRITEBACK;
                    en      <= EN_WB;
                    enw     <= wr_q;
                    taken_q <= branch_q & alu_zero;
                end
                S_WRITEBACK: begin
                    state     <= S_FETCH;
                    en        <= EN_FETCH;
                    instr_req <= 1'b1;
                    enw       <= 1'b0;
                    pc        <= pc + PC_STEP + (taken_q ? br_off : '0);
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
